// File: rtl/contador_modo.sv
// Four-mode register: up/down counter bounded by MAX, or left/right shift register.
// Load wins over enable. wrap is a registered pulse. tc and serial_out follow the current mode.
module contador_modo #(
   parameter int unsigned          WIDTH = 4,
   parameter logic [WIDTH-1:0]     MAX   = '1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [1:0]       mode,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             serial_in,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             wrap,
   output logic             serial_out
);

   localparam logic [1:0] MODE_UP    = 2'b00;
   localparam logic [1:0] MODE_DOWN  = 2'b01;
   localparam logic [1:0] MODE_SHL   = 2'b10;
   localparam logic [1:0] MODE_SHR   = 2'b11;

   logic [WIDTH-1:0] count_next;
   logic             wrap_next;

   always_comb begin
      count_next = count;
      wrap_next  = 1'b0;
      if (load) begin
         // The counting modes clamp to MAX. The shift modes take the raw pattern.
         if (!mode[1] && (load_value > MAX))
            count_next = MAX;
         else
            count_next = load_value;
      end else if (enable) begin
         case (mode)
            MODE_UP: begin
               if (count >= MAX) begin
                  count_next = '0;
                  wrap_next  = 1'b1;
               end else begin
                  count_next = count + 1'b1;
               end
            end
            MODE_DOWN: begin
               if (count == '0) begin
                  count_next = MAX;
                  wrap_next  = 1'b1;
               end else begin
                  count_next = count - 1'b1;
               end
            end
            MODE_SHL: count_next = {count[WIDTH-2:0], serial_in};
            MODE_SHR: count_next = {serial_in, count[WIDTH-1:1]};
            default:  count_next = count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
         wrap  <= 1'b0;
      end else begin
         count <= count_next;
         wrap  <= wrap_next;
      end
   end

   always_comb begin
      tc         = 1'b0;
      serial_out = 1'b0;
      case (mode)
         MODE_UP:   tc = (count >= MAX);
         MODE_DOWN: tc = (count == '0);
         MODE_SHL:  serial_out = count[WIDTH-1];
         MODE_SHR:  serial_out = count[0];
         default: begin
            tc         = 1'b0;
            serial_out = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_contador_modo.sv
// Scoreboard bench for contador_modo. Two configurations are driven in lockstep:
// WIDTH=4/MAX=9 and WIDTH=8/MAX=255.
module tb_contador_modo;

   logic       clk;
   logic       reset;
   logic       enable;
   logic [1:0] mode;
   logic       load;
   logic [7:0] load_value;
   logic       serial_in;

   logic [3:0] count_a;
   logic       tc_a, wrap_a, so_a;
   logic [7:0] count_b;
   logic       tc_b, wrap_b, so_b;

   contador_modo #(.WIDTH(4), .MAX(4'd9)) dut_a (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .mode       (mode),
      .load       (load),
      .load_value (load_value[3:0]),
      .serial_in  (serial_in),
      .count      (count_a),
      .tc         (tc_a),
      .wrap       (wrap_a),
      .serial_out (so_a)
   );

   contador_modo #(.WIDTH(8), .MAX(8'd255)) dut_b (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .mode       (mode),
      .load       (load),
      .load_value (load_value),
      .serial_in  (serial_in),
      .count      (count_b),
      .tc         (tc_b),
      .wrap       (wrap_b),
      .serial_out (so_b)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard state: the entries are {count[7:0], wrap, tc, serial_out}
   logic [10:0] exp_a_q[$];
   logic [10:0] exp_b_q[$];
   int n_vec  = 0;
   int n_miss = 0;
   int m_a    = 0;
   int m_b    = 0;

   function automatic void check(input string name, input logic [10:0] act, input logic [10:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got count=%0d wrap=%0b tc=%0b so=%0b, expected count=%0d wrap=%0b tc=%0b so=%0b",
                  name, act[10:3], act[2], act[1], act[0], exp[10:3], exp[2], exp[1], exp[0]);
      end
   endfunction

   // Reference model. It uses plain integer arithmetic on the count value.
   function automatic int next_cnt(input int w, input int mx, input int cnt, input bit ld,
                                   input int lv, input bit en, input int md, input bit si,
                                   output bit wr);
      int lim;
      lim = 1 << w;
      wr  = 1'b0;
      if (ld) return (md < 2) ? ((lv > mx) ? mx : lv) : (lv % lim);
      if (!en) return cnt;
      case (md)
         0: begin
            if (cnt >= mx) begin wr = 1'b1; return 0; end
            return cnt + 1;
         end
         1: begin
            if (cnt == 0) begin wr = 1'b1; return mx; end
            return cnt - 1;
         end
         2: return (cnt * 2 + int'(si)) % lim;
         default: return cnt / 2 + int'(si) * (lim / 2);
      endcase
   endfunction

   function automatic bit tc_of(input int mx, input int cnt, input int md);
      return (md == 0 && cnt >= mx) || (md == 1 && cnt == 0);
   endfunction

   function automatic bit so_of(input int w, input int cnt, input int md);
      if (md == 2) return bit'((cnt / (1 << (w - 1))) % 2);
      if (md == 3) return bit'(cnt % 2);
      return 1'b0;
   endfunction

   function automatic logic [10:0] pack(input int c, input bit w, input bit t, input bit s);
      logic [7:0] c8;
      c8 = c[7:0];
      return {c8, w, t, s};
   endfunction

   // Driver: sets the inputs just after a negedge, runs the model and pushes the expectation.
   task automatic step(input bit ld, input int lv, input bit en, input int md, input bit si);
      bit w_a, w_b;
      int na, nb;
      @(negedge clk);
      #1;
      load       = ld;
      load_value = lv[7:0];
      enable     = en;
      mode       = md[1:0];
      serial_in  = si;
      na = next_cnt(4, 9, m_a, ld, lv % 16, en, md, si, w_a);
      nb = next_cnt(8, 255, m_b, ld, lv % 256, en, md, si, w_b);
      m_a = na;
      m_b = nb;
      @(posedge clk);
      exp_a_q.push_back(pack(na, w_a, tc_of(9, na, md), so_of(4, na, md)));
      exp_b_q.push_back(pack(nb, w_b, tc_of(255, nb, md), so_of(8, nb, md)));
   endtask

   // Reset is raised between edges, after the monitor has sampled.
   // load and enable stay high across an edge while reset is high.
   task automatic mid_reset(input string tag);
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      check({tag, "_async_a"}, {4'd0, count_a, wrap_a, 2'b00}, 11'd0);
      check({tag, "_async_b"}, {count_b, wrap_b, 2'b00}, 11'd0);
      load   = 1'b1;
      enable = 1'b1;
      mode   = 2'b00;
      @(posedge clk);
      #1;
      check({tag, "_hold_a"}, {4'd0, count_a, wrap_a, 2'b00}, 11'd0);
      check({tag, "_hold_b"}, {count_b, wrap_b, 2'b00}, 11'd0);
      @(negedge clk);
      #1;
      reset  = 1'b0;
      load   = 1'b0;
      enable = 1'b0;
      m_a = 0;
      m_b = 0;
   endtask

   // Monitor: at every negedge it pops and compares one pending expectation per DUT.
   always @(negedge clk) begin
      if (exp_a_q.size() > 0)
         check("cfg4", {4'd0, count_a, wrap_a, tc_a, so_a}, exp_a_q.pop_front());
      if (exp_b_q.size() > 0)
         check("cfg8", {count_b, wrap_b, tc_b, so_b}, exp_b_q.pop_front());
   end

   initial begin
      reset      = 1'b1;
      enable     = 1'b0;
      mode       = 2'b00;
      load       = 1'b0;
      load_value = 8'd0;
      serial_in  = 1'b0;
      #3;
      check("reset_a", {4'd0, count_a, wrap_a, 2'b00}, 11'd0);
      check("reset_b", {count_b, wrap_b, 2'b00}, 11'd0);
      @(negedge clk);
      #1;
      reset = 1'b0;

      // Count up 11 edges: 1..9, 0, 1. wrap is seen with the 0 and tc at 9.
      for (int i = 0; i < 11; i++) step(0, 0, 1, 0, 0);
      // Count down from 0: wrap to 9, then 8.
      step(1, 0, 0, 0, 0);
      step(0, 0, 1, 1, 0);
      step(0, 0, 1, 1, 0);
      // Load 13: it clamps in up mode and is kept raw in shift-left mode.
      step(1, 13, 0, 0, 0);
      step(1, 13, 0, 2, 0);
      // 1001 shifted right twice with serial_in=0.
      step(1, 9, 0, 3, 0);
      step(0, 0, 1, 3, 0);
      step(0, 0, 1, 3, 0);
      // Shift leaves 13 out of range. Up mode then wraps it to 0.
      step(1, 13, 0, 2, 0);
      step(0, 0, 1, 0, 0);
      // The 8-bit config wraps 255 to 0.
      step(1, 255, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      // Reset between edges while the count is 7.
      step(1, 7, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      mid_reset("rst_at7");
      // Reset while a wrap pulse is showing.
      step(1, 9, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      mid_reset("rst_wrap");
      step(0, 0, 1, 0, 0);

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 7) == 0), int'($urandom_range(0, 255)),
              ($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)),
              bit'($urandom_range(0, 1)));
         if (i % 200 == 150) mid_reset("rst_rand");
      end

      @(negedge clk);
      @(negedge clk);
      n_vec++;
      if (exp_a_q.size() != 0 || exp_b_q.size() != 0) begin
         n_miss++;
         $display("FAIL drain: %0d/%0d entries left, expected 0", exp_a_q.size(), exp_b_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/contador_modo.md
CONTADOR_MODO -- requirements
Module: contador_modo

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4: count/data width in bits, legal range 2..32.
REQ-002 The block SHALL have parameter MAX, default 2**WIDTH-1: highest count value in counting modes, legal range 1..2**WIDTH-1.
REQ-003 The block SHALL have port clk  input  1: single clock; all state changes on posedge.
REQ-004 The block SHALL have port reset  input  1: reset, asynchronous, active-high.
REQ-005 The block SHALL have port enable  input  1: advance count/shift on the current edge when high.
REQ-006 The block SHALL have port mode  input  2: 00 count up, 01 count down, 10 shift left, 11 shift right.
REQ-007 The block SHALL have port load  input  1: synchronous parallel load.
REQ-008 The block SHALL have port load_value  input  WIDTH: value captured on load.
REQ-009 The block SHALL have port serial_in  input  1: bit shifted in during shift modes.
REQ-010 The block SHALL have port count  output  WIDTH: registered state.
REQ-011 The block SHALL have port tc  output  1: terminal count, combinational from count and mode.
REQ-012 The block SHALL have port wrap  output  1: registered one-cycle pulse on count wrap-around.
REQ-013 The block SHALL have port serial_out  output  1: bit leaving the register in the current shift direction, combinational.

Function
REQ-014 Per-edge priority SHALL be: load, then enable, then hold; enable and mode are don't-care while load is high.
REQ-015 On load, count SHALL take min(load_value, MAX) in modes 00/01 and load_value unmodified in modes 10/11; wrap SHALL be 0 that cycle.
REQ-016 Mode 00 with enable: count SHALL go to count+1, or to 0 when count>=MAX.
REQ-017 Mode 01 with enable: count SHALL go to count-1, or to MAX when count==0.
REQ-018 Mode 10 with enable: count SHALL go to {count[WIDTH-2:0], serial_in}; MAX not applied.
REQ-019 Mode 11 with enable: count SHALL go to {serial_in, count[WIDTH-1:1]}; MAX not applied.
REQ-020 wrap SHALL be 1 in the cycle after an edge that took 00 from count>=MAX to 0 or 01 from 0 to MAX; otherwise 0, never set in shift modes.
REQ-021 tc SHALL be 1 iff (mode==00 and count>=MAX) or (mode==01 and count==0); always 0 in modes 10/11.
REQ-022 serial_out SHALL be count[WIDTH-1] in mode 10, count[0] in mode 11, and 0 in modes 00/01.
REQ-023 A mode change SHALL take effect on the same edge it is sampled, with no extra latency or state flush.
REQ-024 An out-of-range count (>MAX, left by a shift mode) entering mode 00 SHALL wrap to 0 on the next enabled edge with wrap pulse; entering mode 01 SHALL decrement normally.
REQ-025 With enable low and load low, count SHALL hold and wrap SHALL be 0.

Reset
REQ-026 reset high SHALL immediately, without waiting for clk, force count=0 and wrap=0.
REQ-027 While reset is high, load and enable SHALL be ignored.
REQ-028 The first edge after reset falls SHALL be processed normally per REQ-014; reset during a wrap cycle SHALL clear wrap at once.

Verification (WIDTH=4, MAX=9 unless stated)
REQ-029 Bench SHALL cover: reset, mode=00, enable=1 for 11 edges -> count 1..9,0,1; tc=1 at count 9; wrap=1 exactly in the cycle count shows 0.
REQ-030 Bench SHALL cover: count=0, mode=01, enable=1 -> count 9, then 8; wrap=1 one cycle; tc=1 while count=0.
REQ-031 Bench SHALL cover: load=1, load_value=13, mode=00 -> count 9; same in mode 10 -> count 13, serial_out=1.
REQ-032 Bench SHALL cover: count=4'b1001, mode=11, serial_in=0, 2 edges -> 0100, 0010; serial_out 1, 0, 0; wrap stays 0.
REQ-033 Bench SHALL cover: reset asserted mid-cycle between edges at count=7 -> count 0 before next posedge; load and enable high during reset have no effect.
REQ-034 Bench SHALL cover: WIDTH=8, MAX=255, mode=00 from 255 -> count 0, wrap=1, tc=1 at 255.
